irq_pending_ctrl: RTL and testbench

Interrupt source controller that sits between the SoC interrupt sources and the core's 32-bit `irq_i` interrupt interface. It latches edge-type sources into a pending register and passes level-type sources through a register stage. It gates both with a software enable mask and clears edge-pending bits on the core's `irq_ack_o`/`irq_id_o` handshake. After each acknowledge it applies a short hold-off on the acknowledged line and flags acknowledges of lines that were not asserted.

---
 rtl/irq_pending_ctrl_pkg.sv | 23 ++
 rtl/irq_holdoff_fsm.sv | 46 ++++
 rtl/irq_pending_ctrl.sv | 114 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and types for the interrupt pending controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pending_ctrl_pkg;

  // Config register map
  localparam logic [1:0] IRQ_ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_ADDR_PENDING = 2'd1;
  localparam logic [1:0] IRQ_ADDR_SET     = 2'd2;
  localparam logic [1:0] IRQ_ADDR_STATUS  = 2'd3;

  // STATUS register bit positions
  localparam int STATUS_ERR_BIT  = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_ID_LSB   = 8;
  localparam int STATUS_ID_MSB   = 12;

  typedef enum logic [0:0] {
    HOLD_IDLE   = 1'b0,
    HOLD_ACTIVE = 1'b1
  } holdoff_state_e;

endpackage

// File: rtl/irq_holdoff_fsm.sv
// Masks the most recently acknowledged line for HOLDOFF_CYCLES cycles.
// Latency: mask applies the cycle after the ack and lasts HOLDOFF_CYCLES cycles.
// Backpressure: none; every ack restarts the hold-off on the new line.
module irq_holdoff_fsm #(
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ack_i,
  input  logic [4:0]  ack_id_i,
  output logic [31:0] hold_mask,
  output logic        busy,
  output logic [4:0]  last_id
);
  import irq_pending_ctrl_pkg::*;

  localparam logic [3:0] CNT_RELOAD = 4'(HOLDOFF_CYCLES - 1);

  holdoff_state_e state_q;
  logic [3:0]     cnt_q;

  // A new ack always wins: it moves the mask to the new line and reloads the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= HOLD_IDLE;
      cnt_q     <= 4'd0;
      hold_mask <= 32'd0;
      last_id   <= 5'd0;
    end else if (ack_i) begin
      state_q   <= HOLD_ACTIVE;
      cnt_q     <= CNT_RELOAD;
      hold_mask <= 32'd1 << ack_id_i;
      last_id   <= ack_id_i;
    end else if (state_q == HOLD_ACTIVE) begin
      if (cnt_q == 4'd0) begin
        state_q   <= HOLD_IDLE;
        hold_mask <= 32'd0;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign busy = (state_q == HOLD_ACTIVE);

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches edge sources, registers level sources, masks with ENABLE and ack hold-off.
// Latency: source to irq_o 1 cycle; ack clears pend from the next cycle; config writes 1 cycle.
// Backpressure: none; acks of non-asserted lines are flagged, not refused.
module irq_pending_ctrl #(
  parameter logic [31:0] EDGE_MASK      = 32'hFFFF_0000,
  parameter int          HOLDOFF_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] src_i,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  output logic        ack_err_o
);
  import irq_pending_ctrl_pkg::*;

  logic [31:0] src_q;
  logic [31:0] pend_edge_q;
  logic [31:0] enable_q;
  logic        sticky_err_q;
  logic        err_pulse_q;

  logic [31:0] hold_mask;
  logic        hold_busy;
  logic [4:0]  last_id;

  logic [31:0] pend;
  logic [31:0] ack_onehot;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;
  logic        wr_enable, wr_pending, wr_set, wr_status;
  logic        ack_bad;
  logic [31:0] status;

  irq_holdoff_fsm #(
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ack_i     (irq_ack_i),
    .ack_id_i  (irq_id_i),
    .hold_mask (hold_mask),
    .busy      (hold_busy),
    .last_id   (last_id)
  );

  // Level lines come straight from the registered source, edge lines from the latch
  assign pend  = (pend_edge_q & EDGE_MASK) | (src_q & ~EDGE_MASK);
  assign irq_o = pend & enable_q & ~hold_mask;

  assign wr_enable  = cfg_we_i && (cfg_addr_i == IRQ_ADDR_ENABLE);
  assign wr_pending = cfg_we_i && (cfg_addr_i == IRQ_ADDR_PENDING);
  assign wr_set     = cfg_we_i && (cfg_addr_i == IRQ_ADDR_SET);
  assign wr_status  = cfg_we_i && (cfg_addr_i == IRQ_ADDR_STATUS);

  assign ack_onehot = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
  assign ack_bad    = irq_ack_i && !irq_o[irq_id_i];

  // Sets are applied after clears so a fresh edge/SET beats an ack or W1C
  assign pend_set = (src_i & ~src_q) | (wr_set ? cfg_wdata_i : 32'd0);
  assign pend_clr = ack_onehot | (wr_pending ? cfg_wdata_i : 32'd0);

  // Source sampling, edge latch, enable and error bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q        <= 32'd0;
      pend_edge_q  <= 32'd0;
      enable_q     <= 32'd0;
      sticky_err_q <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      src_q       <= src_i;
      pend_edge_q <= ((pend_edge_q & ~pend_clr) | pend_set) & EDGE_MASK;
      if (wr_enable) begin
        enable_q <= cfg_wdata_i;
      end
      err_pulse_q <= ack_bad;
      // A new error outranks a simultaneous clearing write
      if (ack_bad) begin
        sticky_err_q <= 1'b1;
      end else if (wr_status && cfg_wdata_i[STATUS_ERR_BIT]) begin
        sticky_err_q <= 1'b0;
      end
    end
  end

  assign ack_err_o = err_pulse_q;

  // Assemble STATUS from its fields
  always_comb begin
    status                                = 32'd0;
    status[STATUS_ERR_BIT]                = sticky_err_q;
    status[STATUS_BUSY_BIT]               = hold_busy;
    status[STATUS_ID_MSB:STATUS_ID_LSB]   = last_id;
  end

  // Same-cycle register read mux
  always_comb begin
    cfg_rdata_o = 32'd0;
    case (cfg_addr_i)
      IRQ_ADDR_ENABLE:  cfg_rdata_o = enable_q;
      IRQ_ADDR_PENDING: cfg_rdata_o = pend;
      IRQ_ADDR_SET:     cfg_rdata_o = 32'd0;
      IRQ_ADDR_STATUS:  cfg_rdata_o = status;
      default:          cfg_rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_pending_ctrl;

  localparam int          H  = 2;
  localparam logic [31:0] EM = 32'hFFFF_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] src_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic        ack_err_o;

  int n_pass  = 0;
  int n_total = 0;

  irq_pending_ctrl #(
    .EDGE_MASK      (EM),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_i       (src_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rdata_o (cfg_rdata_o),
    .irq_o       (irq_o),
    .irq_ack_i   (irq_ack_i),
    .irq_id_i    (irq_id_i),
    .ack_err_o   (ack_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: what the spec says is latched, not how the RTL stores it
  logic [31:0] m_src_prev, m_pend_edge, m_enable;
  logic        m_sticky, m_err;
  int          m_last_id, m_hold_line, m_hold_left;

  function automatic logic [31:0] m_pend();
    return (m_pend_edge & EM) | (m_src_prev & ~EM);
  endfunction

  function automatic logic [31:0] m_irq();
    logic [31:0] held;
    held = 32'd0;
    if (m_hold_left > 0) held[m_hold_line] = 1'b1;
    return m_pend() & m_enable & ~held;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return m_enable;
      2'd1: return m_pend();
      2'd3: return 32'(m_sticky) | (32'(m_hold_left > 0) << 1) | (32'(m_last_id) << 8);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_src_prev = 0; m_pend_edge = 0; m_enable = 0;
    m_sticky = 0; m_err = 0; m_last_id = 0; m_hold_line = 0; m_hold_left = 0;
  endtask

  // Advance the model by one clock using the inputs applied during that cycle
  task automatic model_step();
    logic [31:0] irq_now, setv, clrv;
    if (rst_i) begin
      model_reset();
      return;
    end
    irq_now = m_irq();
    setv = src_i & ~m_src_prev;
    clrv = 32'd0;
    if (irq_ack_i) clrv[irq_id_i] = 1'b1;
    if (cfg_we_i && cfg_addr_i == 2'd2) setv = setv | cfg_wdata_i;
    if (cfg_we_i && cfg_addr_i == 2'd1) clrv = clrv | cfg_wdata_i;
    m_pend_edge = ((m_pend_edge & ~clrv) | setv) & EM;
    m_err = irq_ack_i && !irq_now[irq_id_i];
    if (m_err) m_sticky = 1'b1;
    else if (cfg_we_i && cfg_addr_i == 2'd3 && cfg_wdata_i[0]) m_sticky = 1'b0;
    if (cfg_we_i && cfg_addr_i == 2'd0) m_enable = cfg_wdata_i;
    if (irq_ack_i) begin
      m_hold_line = int'(irq_id_i);
      m_hold_left = H;
      m_last_id   = int'(irq_id_i);
    end else if (m_hold_left > 0) begin
      m_hold_left = m_hold_left - 1;
    end
    m_src_prev = src_i;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    check("irq_o", irq_o, m_irq());
    check("ack_err_o", {31'd0, ack_err_o}, {31'd0, m_err});
    check("cfg_rdata_o", cfg_rdata_o, m_read(cfg_addr_i));
  end

  task automatic cyc(input logic [31:0] s, input logic we, input logic [1:0] a,
                     input logic [31:0] wd, input logic ack, input logic [4:0] id);
    src_i = s; cfg_we_i = we; cfg_addr_i = a; cfg_wdata_i = wd;
    irq_ack_i = ack; irq_id_i = id;
    @(posedge clk_i);
    model_step();
    #2;
  endtask

  task automatic idle(input logic [31:0] s);
    cyc(s, 1'b0, 2'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    cfg_we_i = 1'b0; cfg_addr_i = a;
    #1;
    check(name, cfg_rdata_o, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    #1;
    idle(32'd0);
    idle(32'd0);
    rst_i = 1'b0;
  endtask

  function automatic logic [4:0] pick_line(input logic [31:0] v);
    int start;
    start = int'($urandom_range(0, 31));
    for (int k = 0; k < 32; k++) begin
      if (v[(start + k) % 32]) return 5'((start + k) % 32);
    end
    return 5'(start);
  endfunction

  initial begin
    logic [31:0] s;
    logic        we, ack;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [4:0]  id;

    rst_i = 1'b1;
    src_i = 0; cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0; irq_ack_i = 0; irq_id_i = 0;
    model_reset();
    idle(32'd0);
    idle(32'd0);
    check("reset_irq", irq_o, 32'd0);
    check("reset_err", {31'd0, ack_err_o}, 32'd0);
    rd(2'd3, "reset_status", 32'd0);
    rst_i = 1'b0;

    // Edge line 16 latches, holds after source drops, ack hold-off, re-edge during hold
    cyc(32'd0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    idle(32'd0); idle(32'd0);
    idle(32'h0001_0000);
    check("edge16_set", irq_o & 32'h0001_0000, 32'h0001_0000);
    idle(32'd0); idle(32'd0);
    check("edge16_kept", irq_o & 32'h0001_0000, 32'h0001_0000);
    cyc(32'd0, 1'b0, 2'd0, 32'd0, 1'b1, 5'd16);
    check("ack16_hold1", irq_o & 32'h0001_0000, 32'd0);
    idle(32'h0001_0000);
    check("ack16_hold2", irq_o & 32'h0001_0000, 32'd0);
    idle(32'd0);
    check("edge16_back", irq_o & 32'h0001_0000, 32'h0001_0000);
    cyc(32'd0, 1'b0, 2'd0, 32'd0, 1'b1, 5'd16);
    idle(32'd0); idle(32'd0); idle(32'd0);
    check("all_clear", irq_o, 32'd0);

    // Level line 3: ack only masks, W1C ignored
    idle(32'h8);
    check("lvl3_on", irq_o, 32'h8);
    cyc(32'h8, 1'b0, 2'd0, 32'd0, 1'b1, 5'd3);
    check("lvl3_hold1", irq_o, 32'd0);
    idle(32'h8);
    check("lvl3_hold2", irq_o, 32'd0);
    idle(32'h8);
    check("lvl3_back", irq_o, 32'h8);
    cyc(32'h8, 1'b1, 2'd1, 32'h8, 1'b0, 5'd0);
    rd(2'd1, "lvl3_w1c_ignored", 32'h8);
    idle(32'd0);
    idle(32'd0);

    // Invalid ack of line 7
    cyc(32'd0, 1'b0, 2'd0, 32'd0, 1'b1, 5'd7);
    check("ack7_err_pulse", {31'd0, ack_err_o}, 32'd1);
    idle(32'd0);
    check("ack7_err_gone", {31'd0, ack_err_o}, 32'd0);
    idle(32'd0);
    rd(2'd3, "ack7_status", 32'h0000_0701);
    cyc(32'd0, 1'b1, 2'd3, 32'h1, 1'b0, 5'd0);
    rd(2'd3, "ack7_status_clr", 32'h0000_0700);

    // Edge on 20 in the same cycle as its ack keeps it pending
    idle(32'h0010_0000);
    idle(32'd0);
    check("e20_on", irq_o, 32'h0010_0000);
    cyc(32'h0010_0000, 1'b0, 2'd0, 32'd0, 1'b1, 5'd20);
    rd(2'd1, "e20_still_pend", 32'h0010_0000);
    idle(32'd0);
    check("e20_held", irq_o, 32'd0);
    idle(32'd0);
    rd(2'd3, "e20_status", 32'h0000_1400);
    check("e20_back", irq_o, 32'h0010_0000);

    // SET with ENABLE=0, then enable, then reset mid-hold-off
    do_reset();
    cyc(32'd0, 1'b1, 2'd2, 32'h0001_0000, 1'b0, 5'd0);
    rd(2'd1, "set_pend", 32'h0001_0000);
    check("set_masked", irq_o, 32'd0);
    cyc(32'd0, 1'b1, 2'd0, 32'h0001_0000, 1'b0, 5'd0);
    check("set_enabled", irq_o, 32'h0001_0000);
    cyc(32'd0, 1'b0, 2'd0, 32'd0, 1'b1, 5'd16);
    rst_i = 1'b1;
    model_reset();
    rd(2'd0, "rst_enable", 32'd0);
    rd(2'd1, "rst_pend", 32'd0);
    rd(2'd3, "rst_status", 32'd0);
    check("rst_irq", irq_o, 32'd0);
    idle(32'd0);
    rst_i = 1'b0;

    // Randomized traffic against the model
    s = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
        s = 32'd0;
      end
      s  = s ^ ($urandom & $urandom & $urandom);
      we = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd0 && $urandom_range(0, 3) != 0) wd = 32'hFFFF_FFFF;
      ack = ($urandom_range(0, 4) == 0);
      id  = ($urandom_range(0, 1) == 0) ? pick_line(m_irq()) : 5'($urandom_range(0, 31));
      cyc(s, we, a, wd, ack, id);
    end
    idle(32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
